// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the core sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;
    localparam int REG_W   = 8;
    localparam int OP_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_JMPC = 4'b1000;
    localparam logic [OP_W-1:0] OP_JMPD = 4'b1001;
    localparam logic [OP_W-1:0] OP_JMPS = 4'b1010;
    localparam logic [OP_W-1:0] OP_RET  = 4'b1011;
    localparam logic [OP_W-1:0] OP_MEMR = 4'b1100;
    localparam logic [OP_W-1:0] OP_MEMW = 4'b1101;
    localparam logic [OP_W-1:0] OP_LDI  = 4'b1110;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    // ALU (00xx), SRU (01xx) and LDI write the register file from EXEC.
    function automatic logic writes_rf_in_exec(input logic [OP_W-1:0] op);
        return (op[3:2] == 2'b00) || (op[3:2] == 2'b01) || (op == OP_LDI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
// ============================================================================
// Module      : ret_stack
// Description : Circular return-address stack with saturating occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ret_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] top
);

    localparam int              C_AW    = $clog2(DEPTH);
    localparam logic [C_AW:0]   C_FULL  = (C_AW + 1)'(DEPTH);
    localparam logic [C_AW:0]   C_ONE_S = (C_AW + 1)'(1);
    localparam logic [C_AW-1:0] C_ONE_A = C_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr;
    logic [C_AW:0]    r_sp;
    logic [C_AW-1:0]  w_rd;

    // The write index wraps freely, so an overflowing push lands on the oldest
    // entry and an underflowing pop reads whatever slot lies below.
    assign w_rd  = r_wr - C_ONE_A;
    assign top   = r_mem[w_rd];
    assign full  = (r_sp == C_FULL);
    assign empty = (r_sp == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr <= '0;
            r_sp <= '0;
        end else if (push) begin
            r_wr <= r_wr + C_ONE_A;
            if (!full) begin
                r_sp <= r_sp + C_ONE_S;
            end
        end else if (pop) begin
            r_wr <= w_rd;
            if (!empty) begin
                r_sp <= r_sp - C_ONE_S;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clear) begin
            r_mem[r_wr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle instruction sequencer with a return stack.
//               Define SEQ_STACK_GUARD_EN to halt on stack over/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_sequencer
    import core_pkg::*;
#(
    parameter logic [PC_W-1:0] START_PC    = 12'd3,
    parameter int              STACK_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  ir,
    input  logic [REG_W-1:0]    jmp_reg,
    input  logic                cond_zero,
    output logic                rf_we,
    output logic                dmem_we,
    output logic [PC_W-1:0]     pc,
    output logic                running,
    output logic                halted,
    output logic                stack_err
);

`ifdef SEQ_STACK_GUARD_EN
    localparam bit C_GUARD_EN = 1'b1;
`else
    localparam bit C_GUARD_EN = 1'b0;
`endif

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_stack_err;

    logic [OP_W-1:0]    w_op;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_jmp_target;
    logic [PC_W-1:0]    w_pc_next;
    logic [PC_W-1:0]    w_stack_top;
    logic               w_in_exec;
    logic               w_is_jmps;
    logic               w_is_ret;
    logic               w_stk_full;
    logic               w_stk_empty;
    logic               w_fault;
    logic               w_push;
    logic               w_pop;
    logic               w_clear;

    assign w_op         = r_ir[INSTR_W-1:INSTR_W-OP_W];
    assign w_pc_inc     = r_pc + 12'd1;
    assign w_jmp_target = {{(PC_W - REG_W){1'b0}}, jmp_reg};
    assign w_in_exec    = (r_state == ST_EXEC);
    assign w_is_jmps    = w_in_exec && (w_op == OP_JMPS);
    assign w_is_ret     = w_in_exec && (w_op == OP_RET);

    // A guarded fault freezes pc and the stack; without the guard this is constant 0.
    assign w_fault = C_GUARD_EN && ((w_is_jmps && w_stk_full) || (w_is_ret && w_stk_empty));
    assign w_push  = w_is_jmps && !w_fault;
    assign w_pop   = w_is_ret && !w_fault;
    assign w_clear = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .full      (w_stk_full),
        .empty     (w_stk_empty),
        .top       (w_stack_top)
    );

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_op)
            OP_JMPC: if (cond_zero) w_pc_next = w_jmp_target;
            OP_JMPD: w_pc_next = r_ir[PC_W-1:0];
            OP_JMPS: w_pc_next = w_jmp_target;
            OP_RET:  w_pc_next = w_stack_top;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_stack_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_pc    <= START_PC;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir    <= imem_data;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_op == OP_HALT) begin
                        r_state <= ST_HALT;
                    end else if (w_fault) begin
                        r_state     <= ST_HALT;
                        r_stack_err <= 1'b1;
                    end else if ((w_op == OP_MEMR) || (w_op == OP_MEMW)) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_FETCH;
                        r_pc    <= w_pc_next;
                    end
                end
                ST_MEM: begin
                    r_state <= ST_FETCH;
                    r_pc    <= w_pc_inc;
                end
                ST_HALT: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_pc    <= START_PC;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked by rst so an aborted instruction never writes.
    assign rf_we   = !rst && ((w_in_exec && writes_rf_in_exec(w_op)) ||
                              ((r_state == ST_MEM) && (w_op == OP_MEMR)));
    assign dmem_we = !rst && w_in_exec && (w_op == OP_MEMW);

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign running   = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign halted    = (r_state == ST_HALT);
    assign stack_err = r_stack_err;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// ============================================================================
// Module      : tb_core_sequencer
// Description : Self-checking bench for core_sequencer (honours SEQ_STACK_GUARD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_sequencer;

`ifdef SEQ_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int          DEPTH    = 8;
    localparam logic [11:0] START_PC = 12'h003;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic [7:0]  jmp_reg;
    logic        cond_zero;
    logic        rf_we;
    logic        dmem_we;
    logic [11:0] pc;
    logic        running;
    logic        halted;
    logic        stack_err;

    logic [15:0] imem [4096];
    logic [7:0]  rf [16];

    int total = 0;
    int bad   = 0;

    logic [11:0] m_pc;
    logic [11:0] m_stack [$];
    bit          m_err;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic [3:0]  rfp;
        logic [3:0]  dmp;
        logic [11:0] npc;
        logic        halt;
    } vec_t;
    vec_t tbl [13];

    core_sequencer #(
        .START_PC    (12'd3),
        .STACK_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .ir        (ir),
        .jmp_reg   (jmp_reg),
        .cond_zero (cond_zero),
        .rf_we     (rf_we),
        .dmem_we   (dmem_we),
        .pc        (pc),
        .running   (running),
        .halted    (halted),
        .stack_err (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= imem[imem_addr];

    assign jmp_reg   = rf[ir[11:8]];
    assign cond_zero = (rf[ir[7:4]] == 8'h00);

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before test end");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge inside FETCH; observes lat cycles of one instruction.
    task automatic run_instr(input logic [11:0] addr, input logic [15:0] instr, input int lat,
                             input bit poke, output logic [3:0] rfp, output logic [3:0] dmp,
                             output logic [11:0] pc_after, output logic halt_after);
        imem[addr] = instr;
        rfp = '0;
        dmp = '0;
        for (int c = 0; c < lat; c++) begin
            rfp[c] = rf_we;
            dmp[c] = dmem_we;
            if (poke && c == 1) start = 1'b1;
            if (c == 2) start = 1'b0;
            @(negedge clk);
        end
        start      = 1'b0;
        pc_after   = pc;
        halt_after = halted;
    endtask

    // Instruction-level reference: semantics, latency and strobe timing per opcode.
    task automatic model_step(input logic [15:0] instr, input bit poke, input string tag);
        logic [3:0]  op;
        int          lat;
        logic [3:0]  erf, edm, rfp, dmp;
        logic [11:0] nxt, pc_a, at;
        logic        eh, h_a;
        op  = instr[15:12];
        at  = m_pc;
        lat = (op == 4'hC || op == 4'hD) ? 4 : 3;
        erf = 4'b0000;
        edm = 4'b0000;
        eh  = 1'b0;
        nxt = m_pc + 12'd1;
        if (op[3:2] == 2'b00 || op[3:2] == 2'b01 || op == 4'hE) erf = 4'b0100;
        if (op == 4'hC) erf = 4'b1000;
        if (op == 4'hD) edm = 4'b0100;
        case (op)
            4'h8: if (rf[instr[7:4]] == 8'h00) nxt = {4'h0, rf[instr[11:8]]};
            4'h9: nxt = instr[11:0];
            4'hA: begin
                if (GUARD && m_stack.size() == DEPTH) begin
                    eh = 1'b1; nxt = m_pc; m_err = 1'b1;
                end else begin
                    if (m_stack.size() == DEPTH) void'(m_stack.pop_front());
                    m_stack.push_back(m_pc + 12'd1);
                    nxt = {4'h0, rf[instr[11:8]]};
                end
            end
            4'hB: begin
                if (m_stack.size() == 0) begin
                    eh = 1'b1; nxt = m_pc; m_err = 1'b1;
                end else begin
                    nxt = m_stack.pop_back();
                end
            end
            4'hF: begin eh = 1'b1; nxt = m_pc; end
            default: ;
        endcase
        run_instr(at, instr, lat, poke, rfp, dmp, pc_a, h_a);
        check($sformatf("%s rf_we@%0h", tag, at), rfp, erf);
        check($sformatf("%s dmem_we@%0h", tag, at), dmp, edm);
        check($sformatf("%s next_pc@%0h", tag, at), pc_a, nxt);
        check($sformatf("%s halted@%0h", tag, at), h_a, eh);
        m_pc = nxt;
    endtask

    task automatic model_restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_pc = START_PC;
        m_stack.delete();
        check("restart pc", pc, 12'h003);
        check("restart running", running, 1'b1);
    endtask

    logic [3:0]  o_rfp, o_dmp, rop;
    logic [11:0] o_pc, cur;
    logic        o_h;

    initial begin
        tbl[0]  = '{16'hE105, 3, 4'b0100, 4'b0000, 12'h004, 1'b0};
        tbl[1]  = '{16'hD123, 4, 4'b0000, 4'b0100, 12'h005, 1'b0};
        tbl[2]  = '{16'hC210, 4, 4'b1000, 4'b0000, 12'h006, 1'b0};
        tbl[3]  = '{16'h0123, 3, 4'b0100, 4'b0000, 12'h007, 1'b0};
        tbl[4]  = '{16'h4567, 3, 4'b0100, 4'b0000, 12'h008, 1'b0};
        tbl[5]  = '{16'h8200, 3, 4'b0000, 4'b0000, 12'h020, 1'b0};
        tbl[6]  = '{16'h8260, 3, 4'b0000, 4'b0000, 12'h021, 1'b0};
        tbl[7]  = '{16'h9010, 3, 4'b0000, 4'b0000, 12'h010, 1'b0};
        tbl[8]  = '{16'hA400, 3, 4'b0000, 4'b0000, 12'h040, 1'b0};
        tbl[9]  = '{16'hB000, 3, 4'b0000, 4'b0000, 12'h011, 1'b0};
        tbl[10] = '{16'h9FFF, 3, 4'b0000, 4'b0000, 12'hFFF, 1'b0};
        tbl[11] = '{16'h1000, 3, 4'b0100, 4'b0000, 12'h000, 1'b0};
        tbl[12] = '{16'hF000, 3, 4'b0000, 4'b0000, 12'h000, 1'b1};

        for (int a = 0; a < 4096; a++) imem[a] = 16'h0000;
        for (int k = 0; k < 16; k++) rf[k] = 8'h5A;
        rf[0] = 8'h00; rf[2] = 8'h20; rf[4] = 8'h40; rf[6] = 8'h07;
        m_err = 1'b0;

        // Reset, with start held alongside rst on the last reset cycle.
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("reset pc", pc, 12'h000);
        check("reset imem_addr", imem_addr, 12'h000);
        check("reset ir", ir, 16'h0000);
        check("reset running", running, 1'b0);
        check("reset halted", halted, 1'b0);
        check("reset stack_err", stack_err, 1'b0);
        check("reset rf_we", rf_we, 1'b0);
        check("reset dmem_we", dmem_we, 1'b0);
        @(negedge clk);
        check("start under rst ignored", running, 1'b0);

        // Directed program from the vector table.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first fetch pc", pc, 12'h003);
        cur = START_PC;
        for (int i = 0; i < 13; i++) begin
            run_instr(cur, tbl[i].instr, tbl[i].lat, (i == 3), o_rfp, o_dmp, o_pc, o_h);
            check($sformatf("vec%0d rf_we", i), o_rfp, tbl[i].rfp);
            check($sformatf("vec%0d dmem_we", i), o_dmp, tbl[i].dmp);
            check($sformatf("vec%0d next_pc", i), o_pc, tbl[i].npc);
            check($sformatf("vec%0d halted", i), o_h, tbl[i].halt);
            check($sformatf("vec%0d ir", i), ir, tbl[i].instr);
            cur = tbl[i].npc;
        end
        check("halt running", running, 1'b0);

        // Nine nested calls: targets 0x40, 0x50, ... 0xC0 via r1..r9.
        for (int k = 0; k < 16; k++) rf[k] = 8'(8'h30 + 16 * k);
        model_restart();
        for (int k = 1; k <= 9; k++) model_step({4'hA, 4'(k), 8'h00}, 1'b0, "nest");
`ifdef SEQ_STACK_GUARD_EN
        check("nest overflow halted", halted, 1'b1);
        check("nest overflow stack_err", stack_err, 1'b1);
        check("nest overflow pc", pc, 12'h0B0);
        model_restart();
        check("restart keeps stack_err", stack_err, 1'b1);
        model_step(16'hB000, 1'b0, "ret empty");
        check("underflow pc", pc, 12'h003);
        check("underflow stack_err", stack_err, 1'b1);
`else
        check("nest no halt", halted, 1'b0);
        check("nest no stack_err", stack_err, 1'b0);
        check("nest pc", pc, 12'h0C0);
        for (int k = 0; k < 8; k++) model_step(16'hB000, 1'b0, "unwind");
        check("unwind end pc", pc, 12'h041);
        model_step(16'hF000, 1'b0, "halt");
`endif

        // rst during MEM of a MEMR aborts the register write.
        imem[3] = 16'hC000;
        model_restart();
        repeat (3) @(negedge clk);
        check("memr rf_we in MEM", rf_we, 1'b1);
        rst = 1'b1;
        #1;
        check("rst in MEM rf_we", rf_we, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("post-rst running", running, 1'b0);
        check("post-rst halted", halted, 1'b0);
        check("post-rst pc", pc, 12'h000);
        check("post-rst stack_err", stack_err, 1'b0);
        m_err = 1'b0;

        // Randomised instruction stream against the reference model.
        model_restart();
        for (int n = 0; n < 300; n++) begin
            if (n % 40 == 0) begin
                for (int k = 0; k < 16; k++)
                    rf[k] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            end
            do rop = 4'($urandom_range(0, 14));
            while ((rop == 4'hB && m_stack.size() == 0) ||
                   (rop == 4'hA && m_stack.size() == DEPTH));
            model_step({rop, 12'($urandom)}, ($urandom_range(0, 7) == 0), "rand");
        end
        check("rand stack_err", stack_err, m_err);
        check("rand running", running, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter START_PC, default 12'd3: PC loaded on start.
REQ-002 Parameter STACK_DEPTH, default 8: return-stack entries; power of two.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins execution at START_PC.
REQ-006 imem_addr  output  12  instruction BRAM address (equals pc).
REQ-007 imem_data  input  16  instruction BRAM data; valid one cycle after imem_addr.
REQ-008 ir  output  16  latched instruction presented to the datapath.
REQ-009 jmp_reg  input  8  register-file value RegFile[ir[11:8]], used as jump target.
REQ-010 cond_zero  input  1  high when RegFile[ir[7:4]] == 0.
REQ-011 rf_we  output  1  register-file write strobe.
REQ-012 dmem_we  output  1  data BRAM write strobe.
REQ-013 pc  output  12  current program counter.
REQ-014 running  output  1  high in every state except IDLE and HALT.
REQ-015 halted  output  1  high in HALT.
REQ-016 stack_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-017 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: waits for start, then goes to FETCH with pc = START_PC.
- FETCH -> DECODE; DECODE latches ir <= imem_data.
- EXEC -> MEM for ir[15:12] = 1100 (MEMR) or 1101 (MEMW); otherwise EXEC -> FETCH.
- MEM -> FETCH.
REQ-018 Latency SHALL be 3 cycles per instruction, and 4 cycles for MEMR/MEMW.
REQ-019 rf_we SHALL pulse for exactly one cycle: in EXEC for ir[15:14] = 00 (ALU), 01 (SRU) or ir[15:12] = 1110 (LDI); in MEM for MEMR.
REQ-020 dmem_we SHALL pulse for exactly one cycle, in EXEC, for MEMW only.
REQ-021 PC update SHALL occur in the final cycle of each instruction:
- default: pc + 1, wrapping 12'hFFF -> 12'h000.
- JMPC (1000): {4'b0, jmp_reg} if cond_zero, else pc + 1.
- JMPD (1001): ir[11:0].
- JMPS (1010): push pc + 1, then pc <= {4'b0, jmp_reg}.
- RET (1011): pop into pc.
REQ-022 HALT (1111) SHALL enter HALT with pc unchanged and no strobes.
REQ-023 start SHALL be ignored while running; start in HALT SHALL restart at START_PC, empty the stack and leave stack_err unchanged.
REQ-024 Stack pointer SHALL be log2(STACK_DEPTH)+1 bits wide, counting occupancy 0..STACK_DEPTH.

Reset
REQ-025 On rst: state = IDLE, pc = 0, ir = 0, stack empty, stack_err = 0, all strobes 0.
REQ-026 rst SHALL dominate start and abort any state mid-instruction with no strobe in that cycle.

Configuration
REQ-027 With SEQ_STACK_GUARD_EN defined:
- JMPS with a full stack, or RET with an empty stack, SHALL set stack_err, enter HALT, and leave pc and the stack unchanged.
REQ-028 Without SEQ_STACK_GUARD_EN:
- the pointer SHALL wrap modulo STACK_DEPTH; overflow overwrites the oldest entry, underflow pops a stale entry.
- stack_err SHALL be tied to 0.

Structure
REQ-029 A shared package core_pkg SHALL hold the state enum, opcode constants (OP_JMPC, OP_JMPD, OP_JMPS, OP_RET, OP_MEMR, OP_MEMW, OP_LDI, OP_HALT) and the width constants.
REQ-030 The return stack SHALL be the sub-module ret_stack (push, pop, full, empty, top).

Verification
REQ-031 rst, start, imem[3] = LDI r1,0x05 -> rf_we high in the 3rd cycle after start; pc = 4.
REQ-032 MEMW at pc 4 -> dmem_we exactly one cycle, rf_we 0; next FETCH at pc 5 four cycles after FETCH.
REQ-033 JMPC with cond_zero = 1, jmp_reg = 0x20 -> pc = 0x020; with cond_zero = 0 -> pc = pc + 1.
REQ-034 JMPS jmp_reg = 0x40 at pc 0x010, then RET at 0x040 -> pc = 0x011.
REQ-035 Nine nested JMPS:
- with guard: stack_err = 1, halted = 1.
- without guard: no halt; 8 RETs unwind the most recent 8 return addresses.
REQ-036 rst asserted in MEM of MEMR -> rf_we stays 0; next cycle IDLE, pc = 0.
